cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Write-back, write-allocate controller for the direct-mapped 64-line cache array (4 x 16-bit words per line, 5-bit tag). It sits between the CPU load/store port, the cache array and the line-wide unified memory. It detects hits, evicts dirty victims, fills missing lines, merges store words, and stalls the CPU until each access completes.

Parameters:
- TAG_W, 5, tag width (addr[12:8] of the word address)
- IDX_W, 6, index width (addr[7:2])
- WORD_W, 16, CPU word width; line width is 4*WORD_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_re  in  1  load request, held until cpu_stall is low
- cpu_we  in  1  store request, held until cpu_stall is low
- cpu_addr  in  13  word address: [12:8] tag, [7:2] index, [1:0] word select
- cpu_wdata  in  16  store data
- cpu_rdata  out  16  load data, valid in the cycle cpu_stall is low
- cpu_stall  out  1  high while the access is incomplete
- c_addr  out  11  cache line address {tag,index}
- c_re  out  1  cache read enable
- c_we  out  1  cache line write enable
- c_wdirty  out  1  dirty bit to write
- c_wr_data  out  64  line to write
- c_rd_data  in  64  line read from cache
- c_tag_out  in  5  victim tag
- c_hit  in  1  tag match and valid
- c_dirty  in  1  line valid and dirty
- m_addr  out  11  memory line address
- m_re  out  1  memory line read, held until m_rdy
- m_we  out  1  memory line write, held until m_rdy
- m_wdata  out  64  evicted line
- m_rdata  in  64  fill line, valid with m_rdy
- m_rdy  in  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0 (cpu_stall, c_re, c_we, m_re and m_we low; data and address outputs 0). Reset mid-WB or mid-FILL aborts the transaction in the next cycle, and a late m_rdy is ignored.
- The cache array reads in the high phase and writes in the low phase, so its hit/dirty/data outputs are valid within the same cycle c_re is asserted.
- The cache address always equals cpu_addr[12:2], except in the WB state, where m_addr = {c_tag_out latched, index}.
- FSM states: IDLE, WB, FILL, ALLOC.
- IDLE: c_re = cpu_re|cpu_we.
  - Load hit: cpu_stall=0; cpu_rdata = c_rd_data word selected by addr[1:0] (word 0 = bits [15:0]). Zero stall cycles.
  - Store hit: in the same cycle, c_we=1, c_wdirty=1, c_wr_data = c_rd_data with the selected word replaced by cpu_wdata; cpu_stall=0.
  - Miss with c_dirty=1: cpu_stall=1; latch the victim line and tag; go to WB.
  - Miss with c_dirty=0: cpu_stall=1; go to FILL.
  - No request: cpu_stall=0.
- WB: m_we=1 with m_wdata = the latched victim, until m_rdy, then go to FILL.
- FILL: m_re=1, m_addr = cpu_addr[12:2], until m_rdy; the m_rdata line is latched.
- ALLOC: c_we=1, c_wr_data = the fill line (store word merged if cpu_we), c_wdirty = cpu_we; cpu_stall stays 1; go to IDLE, which replays the access as a hit.
- Miss latency: 2 + memory latency cycles (clean); add write-back latency if dirty.
- cpu_re and cpu_we both high: treated as a store.
- CPU address or data changing while stalled: undefined (protocol violation).
- m_rdy outside WB/FILL is ignored. m_re and m_we are never high together.

Optional Feature:
CACHE_CTRL_STATS_EN
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on each completed IDLE hit, excluding the post-ALLOC replay.
  - miss_cnt increments on each IDLE-to-WB or IDLE-to-FILL transition.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg: state enum {IDLE,WB,FILL,ALLOC}; TAG_W, IDX_W, WORD_W, LINE_W=64 constants; the address field slice positions.
- One sub-module, line_merge: combinational replacement of word[addr[1:0]] in a 64-bit line. It is shared by the store-hit and ALLOC paths.

Test Plan:
- Reset, then load at 0x0004 into the empty cache -> FILL with m_addr=0x001. With m_rdata=0x4444_3333_2222_1111 and m_rdy after 3 cycles: ALLOC writes c_wdirty=0, then the replay hit gives cpu_rdata=0x1111 and the stall drops.
- Store 0xBEEF to 0x0006 after the above -> zero-stall hit; c_wr_data=0x4444_BEEF_2222_1111, c_wdirty=1.
- Load 0x0104 (same index, tag 1, victim dirty) -> WB with m_addr=0x001 and m_wdata=0x4444_BEEF_2222_1111, then FILL with m_addr=0x041; the returned word 0 is delivered.
- Store miss to a clean line -> ALLOC writes the fill line with the merged word and c_wdirty=1; no WB occurs.
- Assert rst during FILL before m_rdy -> next cycle IDLE with all outputs 0; a later m_rdy has no effect.
- With CACHE_CTRL_STATS_EN defined, run the above sequence -> hit_cnt=1 (the store hit), miss_cnt=4 (load miss, dirty load miss, store miss; the aborted FILL counts as a miss).

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
// Word address layout: [12:8] tag, [7:2] index, [1:0] word select.
package cache_pkg;

   localparam int TAG_W   = 5;
   localparam int IDX_W   = 6;
   localparam int WORD_W  = 16;
   localparam int WORDS   = 4;
   localparam int LINE_W  = WORDS * WORD_W;
   localparam int LADDR_W = TAG_W + IDX_W;
   localparam int ADDR_W  = LADDR_W + 2;

   // Field positions inside the CPU word address
   localparam int TAG_MSB = 12;
   localparam int IDX_MSB = 7;
   localparam int IDX_LSB = 2;
   localparam int SEL_MSB = 1;
   localparam int SEL_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB    = 2'd1,
      FILL  = 2'd2,
      ALLOC = 2'd3
   } state_e;

   // Pick one CPU word out of a cache line (word 0 = bits [15:0])
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel);
      return line[WORD_W*int'(sel) +: WORD_W];
   endfunction

endpackage

// File: rtl/line_merge.sv
// Replaces one 16-bit word of a 64-bit cache line; used for store hits and
// for merging store data into a freshly filled line.
module line_merge
   import cache_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [1:0]        sel,
   input  logic [WORD_W-1:0] word,
   output logic [LINE_W-1:0] merged
);

   // Pass the line through with the selected word overwritten
   always_comb begin
      merged = line;
      merged[WORD_W*int'(sel) +: WORD_W] = word;
   end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped 64-line cache.
// Optional build macro CACHE_CTRL_STATS_EN adds saturating hit/miss counters.
module cache_ctrl
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_re,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [WORD_W-1:0]  cpu_wdata,
   output logic [WORD_W-1:0]  cpu_rdata,
   output logic               cpu_stall,
   output logic [LADDR_W-1:0] c_addr,
   output logic               c_re,
   output logic               c_we,
   output logic               c_wdirty,
   output logic [LINE_W-1:0]  c_wr_data,
   input  logic [LINE_W-1:0]  c_rd_data,
   input  logic [TAG_W-1:0]   c_tag_out,
   input  logic               c_hit,
   input  logic               c_dirty,
   output logic [LADDR_W-1:0] m_addr,
   output logic               m_re,
   output logic               m_we,
   output logic [LINE_W-1:0]  m_wdata,
   input  logic [LINE_W-1:0]  m_rdata,
   input  logic               m_rdy
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]        hit_cnt,
   output logic [15:0]        miss_cnt
`endif
);

   state_e              state_q, state_d;
   logic [LINE_W-1:0]   victim_q;
   logic [TAG_W-1:0]    vtag_q;
   logic [LINE_W-1:0]   fill_q;
   logic [LINE_W-1:0]   merge_src;
   logic [LINE_W-1:0]   merged;
   logic                req;
   logic [1:0]          sel;

   assign req = cpu_re | cpu_we;
   assign sel = cpu_addr[SEL_MSB:SEL_LSB];

   // Store hits merge into the line just read; ALLOC merges into the fill line
   assign merge_src = (state_q == ALLOC) ? fill_q : c_rd_data;

   line_merge u_merge (
      .line   (merge_src),
      .sel    (sel),
      .word   (cpu_wdata),
      .merged (merged)
   );

   // Next-state and all outputs, decoded from the current state
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_d   = state_q;
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      c_addr    = cpu_addr[TAG_MSB:IDX_LSB];
      c_re      = 1'b0;
      c_we      = 1'b0;
      c_wdirty  = 1'b0;
      c_wr_data = '0;
      m_addr    = '0;
      m_re      = 1'b0;
      m_we      = 1'b0;
      m_wdata   = '0;

      unique case (state_q)
         IDLE: begin
            c_re = req;
            if (req) begin
               if (c_hit) begin
                  if (cpu_we) begin
                     c_we      = 1'b1;
                     c_wdirty  = 1'b1;
                     c_wr_data = merged;
                  end else begin
                     cpu_rdata = line_word(c_rd_data, sel);
                  end
               end else begin
                  cpu_stall = 1'b1;
                  state_d   = c_dirty ? WB : FILL;
               end
            end
         end
         WB: begin
            cpu_stall = 1'b1;
            m_we      = 1'b1;
            m_addr    = {vtag_q, cpu_addr[IDX_MSB:IDX_LSB]};
            m_wdata   = victim_q;
            if (m_rdy) state_d = FILL;
         end
         FILL: begin
            cpu_stall = 1'b1;
            m_re      = 1'b1;
            m_addr    = cpu_addr[TAG_MSB:IDX_LSB];
            if (m_rdy) state_d = ALLOC;
         end
         ALLOC: begin
            cpu_stall = 1'b1;
            c_we      = 1'b1;
            c_wdirty  = cpu_we;
            c_wr_data = cpu_we ? merged : fill_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Hold every output quiet while reset is asserted
      if (rst) begin
         state_d   = IDLE;
         cpu_rdata = '0;
         cpu_stall = 1'b0;
         c_addr    = '0;
         c_re      = 1'b0;
         c_we      = 1'b0;
         c_wdirty  = 1'b0;
         c_wr_data = '0;
         m_addr    = '0;
         m_re      = 1'b0;
         m_we      = 1'b0;
         m_wdata   = '0;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Capture the dirty victim on a miss and the returned fill line
   always_ff @(posedge clk) begin
      // NOTE: pure data holding registers need no reset; the FSM qualifies when they are used.
      if (state_q == IDLE && req && !c_hit && c_dirty) begin
         victim_q <= c_rd_data;
         vtag_q   <= c_tag_out;
      end
      if (state_q == FILL && m_rdy) begin
         fill_q <= m_rdata;
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   logic replay_q;

   // Saturating hit/miss counters; the IDLE cycle after ALLOC is a replay, not a hit
   always_ff @(posedge clk) begin
      if (rst) begin
         replay_q <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         replay_q <= (state_q == ALLOC);
         if (state_q == IDLE && req && c_hit && !replay_q && hit_cnt != 16'hFFFF)
            hit_cnt <= hit_cnt + 16'd1;
         if (state_q == IDLE && req && !c_hit && miss_cnt != 16'hFFFF)
            miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural cache array and memory
// around the DUT, a word-level reference memory with a direct-mapped policy
// model, and scoreboard queues checked by independent monitors.
`timescale 1ns/1ps
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_re = 1'b0, cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic [10:0] c_addr;
   logic        c_re, c_we, c_wdirty;
   logic [63:0] c_wr_data, c_rd_data;
   logic [4:0]  c_tag_out;
   logic        c_hit, c_dirty;
   logic [10:0] m_addr;
   logic        m_re, m_we;
   logic [63:0] m_wdata, m_rdata;
   logic        m_rdy;
`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wdirty(c_wdirty),
      .c_wr_data(c_wr_data), .c_rd_data(c_rd_data), .c_tag_out(c_tag_out),
      .c_hit(c_hit), .c_dirty(c_dirty), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rdy(m_rdy)
`ifdef CACHE_CTRL_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_now(input string why);
      errors++;
      $display("FAIL %s: bound expired at %0t", why, $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // ---------------- behavioural cache array ----------------
   logic [63:0] arr_data  [64];
   logic [4:0]  arr_tag   [64];
   bit          arr_valid [64];
   bit          arr_dirty [64];
   logic [5:0]  aw_idx;
   logic [4:0]  aw_tag;
   logic [63:0] aw_data;
   bit          aw_dirty;

   assign c_rd_data = arr_data[c_addr[5:0]];
   assign c_tag_out = arr_tag[c_addr[5:0]];
   assign c_hit     = arr_valid[c_addr[5:0]] && (arr_tag[c_addr[5:0]] == c_addr[10:6]);
   assign c_dirty   = arr_valid[c_addr[5:0]] && arr_dirty[c_addr[5:0]];

   always @(negedge clk) begin
      if (c_we) begin
         aw_idx = c_addr[5:0]; aw_tag = c_addr[10:6];
         aw_data = c_wr_data;  aw_dirty = c_wdirty;
         #1;
         arr_data[aw_idx] = aw_data; arr_tag[aw_idx] = aw_tag;
         arr_valid[aw_idx] = 1'b1;   arr_dirty[aw_idx] = aw_dirty;
      end
   end

   // ---------------- behavioural line memory ----------------
   typedef struct { bit is_wr; logic [10:0] addr; logic [63:0] data; } mtx_t;
   mtx_t        mq[$];
   mtx_t        m_exp;
   logic [63:0] mem [2048];
   int          wb_lat = 1, fill_lat = 1;
   int          m_cnt, m_lat;
   bit          m_busy = 0;
   logic        m_rdy_mem = 0, m_rdy_inj = 0;
   logic [63:0] m_rdata_mem = '0, m_rdata_inj = '0;
   logic [10:0] mc_addr;
   logic        mc_wr;
   logic [63:0] mc_data;

   assign m_rdy   = m_rdy_mem | m_rdy_inj;
   assign m_rdata = m_rdy_inj ? m_rdata_inj : m_rdata_mem;

   always begin
      @(negedge clk);
      if (m_re || m_we) begin
         if (!m_busy) begin
            m_busy = 1; m_cnt = 0;
            m_lat  = m_we ? wb_lat : fill_lat;
            check("m_re_we_exclusive", m_re & m_we, 0);
            if (mq.size() == 0) check("mem_tx_unexpected", 1, 0);
            else begin
               m_exp = mq.pop_front();
               check("mem_tx_is_write", m_we, m_exp.is_wr);
               check("mem_tx_addr", m_addr, m_exp.addr);
               if (m_exp.is_wr) check("wb_data", m_wdata, m_exp.data);
            end
         end
         m_cnt++;
         if (m_cnt >= m_lat) begin
            mc_addr = m_addr; mc_wr = m_we; mc_data = m_wdata;
            #2;
            if (mc_wr) mem[mc_addr] = mc_data;
            else       m_rdata_mem  = mem[mc_addr];
            m_rdy_mem = 1;
            @(posedge clk); #1;
            m_rdy_mem = 0; m_busy = 0;
         end
      end else begin
         m_busy = 0;
      end
   end

   // ---------------- reference model (CPU-visible behaviour) ----------------
   typedef struct { bit is_load; logic [15:0] rdata; int stall; } exp_t;
   exp_t        sq[$];
   exp_t        mon_e;
   logic [15:0] ref_mem [8192];
   bit          r_valid [64];
   logic [4:0]  r_tag   [64];
   bit          r_dirty [64];
   int          m_hits = 0, m_misses = 0;

   function automatic logic [63:0] ref_line(input logic [10:0] la);
      logic [63:0] l;
      for (int w = 0; w < 4; w++) l[16*w +: 16] = ref_mem[{la, 2'(w)}];
      return l;
   endfunction

   task automatic model_access(input bit is_store, input logic [12:0] addr,
                               input logic [15:0] wd, output exp_t e);
      logic [5:0] idx = addr[7:2];
      logic [4:0] tag = addr[12:8];
      mtx_t t;
      e.stall = 0;
      if (!(r_valid[idx] && r_tag[idx] == tag)) begin
         m_misses++;
         if (r_valid[idx] && r_dirty[idx]) begin
            t.is_wr = 1; t.addr = {r_tag[idx], idx}; t.data = ref_line(t.addr);
            mq.push_back(t);
            e.stall += wb_lat;
         end
         t.is_wr = 0; t.addr = addr[12:2]; t.data = '0;
         mq.push_back(t);
         e.stall += 2 + fill_lat;
         r_valid[idx] = 1; r_tag[idx] = tag; r_dirty[idx] = 0;
      end else begin
         m_hits++;
      end
      if (is_store) begin
         ref_mem[addr] = wd;
         r_dirty[idx]  = 1;
      end
      e.is_load = !is_store;
      e.rdata   = ref_mem[addr];
   endtask

   // ---------------- completion monitor ----------------
   int mon_stall = 0;
   always @(negedge clk) begin
      if (rst) mon_stall = 0;
      else if (cpu_re || cpu_we) begin
         if (cpu_stall) mon_stall++;
         else begin
            if (sq.size() == 0) check("cpu_unexpected_completion", 1, 0);
            else begin
               mon_e = sq.pop_front();
               check("stall_cycles", mon_stall, mon_e.stall);
               if (mon_e.is_load) check("load_data", cpu_rdata, mon_e.rdata);
            end
            mon_stall = 0;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_access(input bit re, input bit we, input logic [12:0] addr,
                            input logic [15:0] wd);
      exp_t e;
      model_access(we, addr, wd, e);
      sq.push_back(e);
      @(posedge clk); #1;
      cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      for (int i = 0; i <= 40; i++) begin
         @(negedge clk);
         if (!cpu_stall) return;
      end
      finish_now("access_timeout");
   endtask

   task automatic go_idle(input int n);
      @(posedge clk); #1;
      cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      repeat (n) @(posedge clk);
   endtask

   task automatic check_quiet(input string tag);
      @(negedge clk);
      check({tag, "_ctrl_outputs"},
            {cpu_stall, c_re, c_we, c_wdirty, m_re, m_we, c_addr, m_addr, cpu_rdata}, 0);
      check({tag, "_c_wr_data"}, c_wr_data, 0);
      check({tag, "_m_wdata"}, m_wdata, 0);
   endtask

   logic [12:0] r_addr;
   mtx_t        abort_t;

   initial begin
      for (int i = 0; i < 64; i++) begin
         arr_valid[i] = 0; arr_dirty[i] = 0; arr_tag[i] = '0; arr_data[i] = '0;
         r_valid[i] = 0;   r_dirty[i] = 0;   r_tag[i] = '0;
      end
      for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
      mem[11'h001] = 64'h4444_3333_2222_1111;
      for (int i = 0; i < 2048; i++)
         for (int w = 0; w < 4; w++) ref_mem[{11'(i), 2'(w)}] = mem[i][16*w +: 16];

      // Reset state
      repeat (2) @(posedge clk);
      check_quiet("in_reset");
      @(posedge clk); #1; rst = 0;
      check_quiet("after_reset");
`ifdef CACHE_CTRL_STATS_EN
      check("stats_reset", {hit_cnt, miss_cnt}, 0);
`endif

      // Clean load miss, fill latency 3, replay returns word 0
      fill_lat = 3; wb_lat = 2;
      do_access(1, 0, 13'h0004, 16'h0);
      // Store hit, zero stall, word 2 merged
      do_access(0, 1, 13'h0006, 16'hBEEF);
      // Dirty conflict load: write-back of 0x001 then fill of 0x041
      do_access(1, 0, 13'h0104, 16'h0);
      // Store miss to a clean line: fill then merged ALLOC, no write-back
      fill_lat = 2;
      do_access(0, 1, 13'h0209, 16'hA5C3);
      do_access(1, 0, 13'h0209, 16'h0);
      do_access(1, 0, 13'h0208, 16'h0);

      // Abort a FILL with reset; the aborted miss still counts as a miss
      go_idle(1);
      fill_lat = 6;
      abort_t.is_wr = 0; abort_t.addr = 11'h0C0; abort_t.data = '0;
      mq.push_back(abort_t);
      m_misses++;
      @(posedge clk); #1;
      cpu_re = 1; cpu_addr = 13'h0300;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (m_re) break;
         if (i == 5) finish_now("fill_start_timeout");
      end
`ifdef CACHE_CTRL_STATS_EN
      check("hit_cnt_before_abort", hit_cnt, 16'(m_hits));
      check("miss_cnt_before_abort", miss_cnt, 16'(m_misses));
`endif
      @(posedge clk); #1;
      rst = 1; cpu_re = 0; cpu_addr = '0;
      @(posedge clk); #1; rst = 0;
      m_hits = 0; m_misses = 0;
      check_quiet("after_abort");
      // Late m_rdy with nothing outstanding must be ignored
      #2; m_rdata_inj = 64'hDEAD_BEEF_0BAD_F00D; m_rdy_inj = 1;
      @(posedge clk); #1; m_rdy_inj = 0;
      check_quiet("after_late_rdy");
`ifdef CACHE_CTRL_STATS_EN
      check("stats_after_abort", {hit_cnt, miss_cnt}, 0);
`endif

      // Randomized traffic over a few conflicting tags
      do_access(1, 0, 13'h0300, 16'h0);
      for (int n = 0; n < 300; n++) begin
         int op;
         r_addr   = {5'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         op       = $urandom_range(0, 3);
         wb_lat   = $urandom_range(1, 4);
         fill_lat = $urandom_range(1, 4);
         do_access(op != 2, op >= 2, r_addr, 16'($urandom));
         if ($urandom_range(0, 7) == 0) go_idle($urandom_range(1, 3));
      end
      go_idle(4);
      check("sb_drained", sq.size(), 0);
      check("mem_tx_drained", mq.size(), 0);
`ifdef CACHE_CTRL_STATS_EN
      check("hit_cnt_final", hit_cnt, 16'(m_hits));
      check("miss_cnt_final", miss_cnt, 16'(m_misses));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      finish_now("global_time_limit");
   end

endmodule
